// File: rtl/range_counter_param.sv
// Programmable lo..hi range counter with up, down,
// ping-pong and one-shot modes, plus tc and done flags.
module range_counter_param #(
  parameter int              WIDTH     = 6,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    M_UP,
    M_DOWN,
    M_PP,
    M_ONE
  } mode_t;

  state_t           state_q;
  state_t           state_d;
  mode_t            mode_q;
  mode_t            mode_d;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] count_d;
  logic             dir_d;
  logic             tc_d;
  logic             done_d;
  logic             cfg_err_d;

  logic [WIDTH-1:0] step_count;
  logic             step_dir;
  logic             step_tc;
  logic             step_fin;
  logic             at_hi;
  logic             at_lo;
  logic             bad_cfg;
  logic             go_stop;
  logic             go_bad;
  logic             go_start;
  logic             go_step;

  assign at_hi   = (count >= hi_q);
  assign at_lo   = (count <= lo_q);
  assign bad_cfg = (lo > hi);

  assign go_stop  = stop;
  assign go_bad   = !stop && start && bad_cfg;
  assign go_start = !stop && start && !bad_cfg;
  assign go_step  = !stop && !start
                 && (state_q == RUN) && en;

  // Endpoint compares come first so count never
  // steps past hi_q or below lo_q.
  always_comb begin
    step_count = count;
    step_dir   = dir;
    step_tc    = 1'b0;
    step_fin   = 1'b0;
    unique case (mode_q)
      M_UP: begin
        if (at_hi) begin
          step_count = lo_q;
          step_tc    = 1'b1;
        end else begin
          step_count = count + 1'b1;
        end
      end
      M_DOWN: begin
        if (at_lo) begin
          step_count = hi_q;
          step_tc    = 1'b1;
        end else begin
          step_count = count - 1'b1;
        end
      end
      M_PP: begin
        if (lo_q == hi_q) begin
          step_tc = 1'b1;
        end else if (dir) begin
          if (at_hi) begin
            step_count = count - 1'b1;
            step_dir   = 1'b0;
            step_tc    = 1'b1;
          end else begin
            step_count = count + 1'b1;
          end
        end else begin
          if (at_lo) begin
            step_count = count + 1'b1;
            step_dir   = 1'b1;
            step_tc    = 1'b1;
          end else begin
            step_count = count - 1'b1;
          end
        end
      end
      M_ONE: begin
        if (at_hi) begin
          step_fin = 1'b1;
          step_tc  = 1'b1;
        end else begin
          step_count = count + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    count_d   = count;
    dir_d     = dir;
    done_d    = done;
    tc_d      = 1'b0;
    cfg_err_d = 1'b0;
    unique case (1'b1)
      go_stop: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      go_bad: begin
        cfg_err_d = 1'b1;
      end
      go_start: begin
        state_d = RUN;
        mode_d  = mode_t'(mode);
        lo_d    = lo;
        hi_d    = hi;
        done_d  = 1'b0;
        if (mode_t'(mode) == M_DOWN) begin
          count_d = hi;
          dir_d   = 1'b0;
        end else begin
          count_d = lo;
          dir_d   = 1'b1;
        end
      end
      go_step: begin
        count_d = step_count;
        dir_d   = step_dir;
        tc_d    = step_tc;
        if (step_fin) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= M_UP;
      lo_q    <= '0;
      hi_q    <= '0;
      count   <= RESET_VAL;
      dir     <= 1'b1;
      tc      <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      count   <= count_d;
      dir     <= dir_d;
      tc      <= tc_d;
      done    <= done_d;
      cfg_err <= cfg_err_d;
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_range_counter_param.sv
// Directed checks for range_counter_param: reset, modes,
// config error and control priority.
module tb_range_counter_param;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [W-1:0] count;
  logic         dir;
  logic         tc;
  logic         busy;
  logic         done;
  logic         cfg_err;

  int tests = 0;
  int fails = 0;

  range_counter_param #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .en(en), .mode(mode), .lo(lo), .hi(hi),
    .count(count), .dir(dir), .tc(tc), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m,
                          input logic [W-1:0] l,
                          input logic [W-1:0] h);
    mode = m; lo = l; hi = h; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; stop = 0; en = 0;
    mode = 0; lo = 0; hi = 0;
    #12;
    tests++;
    if ({count, dir, tc, busy, done, cfg_err} !== {6'd0, 5'b10000}) begin
      fails++;
      $display("FAIL reset_state got c=%0d d=%b tc=%b b=%b dn=%b ce=%b",
               count, dir, tc, busy, done, cfg_err);
    end
    rst = 1'b1;
    tick();
    en = 1'b1;
    do_start(2'd0, 6'd20, 6'd30);
    repeat (5) tick();
    tests++;
    if (count !== 6'd25 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_run got c=%0d b=%b want 25/1", count, busy);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (count !== 6'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got c=%0d b=%b want 0/0", count, busy);
    end
    tick(); tick();
    tests++;
    if (count !== 6'd0 || busy !== 1'b0 || dir !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold got c=%0d b=%b want 0/0", count, busy);
    end
    rst = 1'b1;
    en = 1'b0;
    tick();
  endtask

  task automatic test_up();
    logic [W-1:0] ec [6] = '{10, 11, 12, 13, 10, 11};
    logic         et [6] = '{0, 0, 0, 0, 1, 0};
    en = 1'b1;
    do_start(2'd0, 6'd10, 6'd13);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (count !== ec[i] || tc !== et[i]) begin
        fails++;
        $display("FAIL up[%0d] got c=%0d tc=%b want c=%0d tc=%b",
                 i, count, tc, ec[i], et[i]);
      end
      tick();
    end
  endtask

  task automatic test_pingpong();
    logic [W-1:0] ec [6] = '{3, 4, 5, 4, 3, 4};
    logic         ed [6] = '{1, 1, 1, 0, 0, 1};
    logic         et [6] = '{0, 0, 0, 1, 0, 1};
    en = 1'b1;
    do_start(2'd2, 6'd3, 6'd5);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (count !== ec[i] || dir !== ed[i] || tc !== et[i]) begin
        fails++;
        $display("FAIL pp[%0d] got c=%0d d=%b tc=%b want c=%0d d=%b tc=%b",
                 i, count, dir, tc, ec[i], ed[i], et[i]);
      end
      tick();
    end
  endtask

  task automatic test_oneshot();
    en = 1'b1;
    do_start(2'd3, 6'd60, 6'd63);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (count !== 6'(60 + i) || busy !== 1'b1 || done !== 1'b0
          || tc !== 1'b0) begin
        fails++;
        $display("FAIL os_run[%0d] got c=%0d b=%b dn=%b tc=%b want c=%0d",
                 i, count, busy, done, tc, 60 + i);
      end
      tick();
    end
    tests++;
    if (count !== 6'd63 || done !== 1'b1 || busy !== 1'b0
        || tc !== 1'b1) begin
      fails++;
      $display("FAIL os_done got c=%0d dn=%b b=%b tc=%b want 63/1/0/1",
               count, done, busy, tc);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (count !== 6'd63 || done !== 1'b1 || busy !== 1'b0
          || tc !== 1'b0) begin
        fails++;
        $display("FAIL os_hold[%0d] got c=%0d dn=%b b=%b tc=%b",
                 i, count, done, busy, tc);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 6'd63) begin
      fails++;
      $display("FAIL os_stop got dn=%b b=%b c=%0d want 0/0/63",
               done, busy, count);
    end
  endtask

  task automatic test_cfg_err();
    en = 1'b1;
    do_start(2'd0, 6'd5, 6'd10);
    tick(); tick();
    en = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++;
    if (count !== 6'd7 || busy !== 1'b0) begin
      fails++;
      $display("FAIL cfg_setup got c=%0d b=%b want 7/0", count, busy);
    end
    do_start(2'd0, 6'd20, 6'd10);
    tests++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || count !== 6'd7) begin
      fails++;
      $display("FAIL cfg_err got ce=%b b=%b c=%0d want 1/0/7",
               cfg_err, busy, count);
    end
    tick();
    tests++;
    if (cfg_err !== 1'b0 || busy !== 1'b0 || count !== 6'd7) begin
      fails++;
      $display("FAIL cfg_err_pulse got ce=%b b=%b c=%0d want 0/0/7",
               cfg_err, busy, count);
    end
  endtask

  task automatic test_control();
    en = 1'b1;
    do_start(2'd1, 6'd0, 6'd4);
    tests++;
    if (count !== 6'd4 || dir !== 1'b0) begin
      fails++;
      $display("FAIL down_start got c=%0d d=%b want 4/0", count, dir);
    end
    tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (count !== 6'd2 || tc !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL en_hold[%0d] got c=%0d tc=%b b=%b want 2/0/1",
                 i, count, tc, busy);
      end
    end
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    tests++;
    if (count !== 6'd2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stop_wins got c=%0d b=%b want 2/0", count, busy);
    end
    en = 1'b1;
    do_start(2'd0, 6'd9, 6'd9);
    tests++;
    if (count !== 6'd9 || tc !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL eq_start got c=%0d tc=%b b=%b want 9/0/1",
               count, tc, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (count !== 6'd9 || tc !== 1'b1) begin
        fails++;
        $display("FAIL eq_run[%0d] got c=%0d tc=%b want 9/1",
                 i, count, tc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_pingpong();
    test_oneshot();
    test_cfg_err();
    test_control();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
